hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning total EX-stage cycles a multiply occupies (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 each, source register addresses of the instruction in ID.
REQ-005 SHALL have ports id_useRa and id_useRb, input, 1 each, meaning the ID instruction reads rs1/rs2.
REQ-006 SHALL have ports ex_rd (input, 5), ex_memRead (input, 1) and ex_regW (input, 1), taken from the ID/EX register outputs.
REQ-007 SHALL have port ex_mul, input, 1, meaning the ID/EX instruction is a multiply (ALU/MUL select = MUL).
REQ-008 SHALL have port ex_redirect, input, 1, meaning the branch/jump in EX is taken.
REQ-009 SHALL have port mem_busy, input, 1, meaning data memory wait.
REQ-010 SHALL have ports stall_pc, stall_ifid, stall_idex and stall_exmem, output, 1 each, hold requests per stage register.
REQ-011 SHALL have ports flush_ifid, flush_idex and flush_exmem, output, 1 each, bubble-insert requests per stage register.
REQ-012 SHALL have ports mul_busy (output, 1, high in MUL_WAIT) and mul_done (output, 1, single-cycle pulse on the final multiply cycle).

Function
REQ-013 SHALL implement a two-state FSM, RUN and MUL_WAIT, plus a 4-bit down-counter cnt.
REQ-014 SHALL evaluate priority as: mem_busy > ex_redirect > multiply > load-use.
REQ-015 mem_busy=1 SHALL assert all four stalls, deassert all flushes, and freeze state and cnt.
REQ-016 ex_redirect=1 (mem_busy=0, RUN) SHALL assert flush_ifid and flush_idex, with no stalls; load-use and multiply detection SHALL be suppressed that cycle.
REQ-017 Load-use is ex_memRead & ex_regW & (ex_rd!=0) & ((id_useRa & id_rs1==ex_rd) | (id_useRb & id_rs2==ex_rd)).
REQ-018 Load-use in RUN SHALL assert stall_pc, stall_ifid and flush_idex for exactly that cycle, with no state change.
REQ-019 In RUN with ex_mul=1 and MUL_LAT>=2: stall_pc, stall_ifid, stall_idex and flush_exmem SHALL be asserted; cnt<=MUL_LAT-2; state<=MUL_WAIT.
REQ-020 In MUL_WAIT with cnt!=0: the same four outputs SHALL be asserted and cnt SHALL decrement.
REQ-021 In MUL_WAIT with cnt==0: stalls SHALL be deasserted, mul_done SHALL be 1, and state<=RUN.
REQ-022 Total stalled cycles per multiply SHALL be MUL_LAT-1; with MUL_LAT=1, MUL_WAIT SHALL never be entered and mul_done SHALL pulse in the detection cycle.
REQ-023 Load-use SHALL be ignored in MUL_WAIT, because ID is already held.
REQ-024 ex_redirect in MUL_WAIT SHALL be ignored; a multiply and a branch cannot share EX.
REQ-025 Back-to-back multiplies SHALL each trigger independently: the RUN cycle following mul_done sees the new EX instruction.
REQ-026 All stall/flush outputs SHALL be combinational from inputs and state; only state and cnt are registered.

Reset
REQ-027 rst=0 SHALL force state=RUN and cnt=0 asynchronously, including mid-multiply.
REQ-028 During reset, all outputs SHALL be 0 unless driven by the combinational paths; mul_busy and mul_done SHALL be 0.
REQ-029 The first rising clk edge after rst release SHALL evaluate in RUN.

Structure
REQ-030 The shared pipeline package SHALL hold the FSM state encoding (RUN=0, MUL_WAIT=1) and the register-address width constant (5).
REQ-031 The block SHALL be a single module with no sub-modules; the counter SHALL be inline.

Verification
REQ-032 Load-use: ex_memRead=1, ex_regW=1, ex_rd=5, id_rs1=5, id_useRa=1 -> one cycle with stall_pc=stall_ifid=flush_idex=1; same stimulus with ex_rd=0 -> no stall.
REQ-033 Multiply, MUL_LAT=4: ex_mul=1 at cycle 0 -> stalls high at cycles 0-2, mul_done=1 at cycle 3, mul_busy high at cycles 1-3.
REQ-034 Redirect plus load-use in the same cycle -> flush_ifid=flush_idex=1, stall_pc=0.
REQ-035 mem_busy=1 for 3 cycles during MUL_WAIT with cnt=1 -> cnt held at 1 and all four stalls high; mul_done follows 2 cycles after mem_busy falls.
REQ-036 rst pulse low at MUL_WAIT cycle 1 -> state=RUN immediately, mul_busy=0; a fresh ex_mul restarts the full MUL_LAT-1 stall.
REQ-037 MUL_LAT=1 with ex_mul=1 -> no stall, and mul_done=1 in the same cycle.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit.
//   hu_state_e : hazard FSM state encoding (RUN=0, MUL_WAIT=1)
//   REG_AW     : register-address width
//   CNT_W      : multiply wait-counter width (covers MUL_LAT up to 15)
`timescale 1ns/1ps
package hazard_unit_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hu_state_e;

endpackage

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush control for memory waits, taken
// redirects, multi-cycle multiplies and load-use hazards.
// Ports:
//   clk, rst (async, active-low)
//   id_rs1/id_rs2, id_useRa/id_useRb     : ID-stage source operands
//   ex_rd, ex_memRead, ex_regW, ex_mul   : ID/EX register contents
//   ex_redirect                          : taken branch/jump in EX
//   mem_busy                             : data-memory wait
//   stall_pc/ifid/idex/exmem             : per-stage hold requests
//   flush_ifid/idex/exmem                : per-stage bubble requests
//   mul_busy, mul_done                   : multiply wait status
// All outputs are combinational from inputs and state; only state and
// the wait counter are registered.
`timescale 1ns/1ps
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_useRa,
    input  logic              id_useRb,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memRead,
    input  logic              ex_regW,
    input  logic              ex_mul,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              stall_exmem,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              mul_busy,
    output logic              mul_done
);

    // Cycles left after the detection cycle and the final (done) cycle.
    localparam logic [CNT_W-1:0] MUL_INIT =
        (MUL_LAT >= 2) ? CNT_W'(MUL_LAT - 2) : '0;

    hu_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and stall/flush decode, highest priority first.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        mul_done    = 1'b0;
        mul_busy    = (state_q == MUL_WAIT);

        load_use = ex_memRead && ex_regW && (ex_rd != '0) &&
                   ((id_useRa && (id_rs1 == ex_rd)) ||
                    (id_useRb && (id_rs2 == ex_rd)));

        if (mem_busy) begin
            // Whole pipe frozen; state and counter hold.
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
        end else if (state_q == MUL_WAIT) begin
            // ID is held and EX holds the multiply: redirect/load-use moot.
            if (cnt_q != '0) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                flush_exmem = 1'b1;
                cnt_d       = cnt_q - CNT_W'(1);
            end else begin
                mul_done = 1'b1;
                state_d  = RUN;
            end
        end else if (ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (ex_mul) begin
            if (MUL_LAT >= 2) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                flush_exmem = 1'b1;
                cnt_d       = MUL_INIT;
                state_d     = MUL_WAIT;
            end else begin
                mul_done = 1'b1;
            end
        end else if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MUL_LAT=4 and MUL_LAT=1).
`timescale 1ns/1ps
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    // Output vector order:
    // stall_pc stall_ifid stall_idex stall_exmem flush_ifid flush_idex flush_exmem mul_busy mul_done
    localparam logic [8:0] NONE  = 9'b000_0000_00;
    localparam logic [8:0] LU    = 9'b110_0010_00;
    localparam logic [8:0] REDIR = 9'b000_0110_00;
    localparam logic [8:0] MULS  = 9'b111_0001_00;
    localparam logic [8:0] MULW  = 9'b111_0001_10;
    localparam logic [8:0] MULD  = 9'b000_0000_11;
    localparam logic [8:0] MEMB  = 9'b111_1000_00;
    localparam logic [8:0] MEMBW = 9'b111_1000_10;
    localparam logic [8:0] MUL1  = 9'b000_0000_01;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_useRa, id_useRb, ex_memRead, ex_regW, ex_mul, ex_mul1;
    logic       ex_redirect, mem_busy;

    logic s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_exmem, m_busy, m_done;
    logic t_pc, t_ifid, t_idex, t_exmem, g_ifid, g_idex, g_exmem, n_busy, n_done;
    logic [8:0] vec, vec1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign vec  = {s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_exmem, m_busy, m_done};
    assign vec1 = {t_pc, t_ifid, t_idex, t_exmem, g_ifid, g_idex, g_exmem, n_busy, n_done};

    hazard_unit #(.MUL_LAT(4)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRa(id_useRa), .id_useRb(id_useRb),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_regW(ex_regW), .ex_mul(ex_mul),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_pc(s_pc), .stall_ifid(s_ifid), .stall_idex(s_idex), .stall_exmem(s_exmem),
        .flush_ifid(f_ifid), .flush_idex(f_idex), .flush_exmem(f_exmem),
        .mul_busy(m_busy), .mul_done(m_done)
    );

    hazard_unit #(.MUL_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRa(id_useRa), .id_useRb(id_useRb),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_regW(ex_regW), .ex_mul(ex_mul1),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_pc(t_pc), .stall_ifid(t_ifid), .stall_idex(t_idex), .stall_exmem(t_exmem),
        .flush_ifid(g_ifid), .flush_idex(g_idex), .flush_exmem(g_exmem),
        .mul_busy(n_busy), .mul_done(n_done)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_useRa = 0; id_useRb = 0;
        ex_rd = '0; ex_memRead = 0; ex_regW = 0; ex_mul = 0; ex_mul1 = 0;
        ex_redirect = 0; mem_busy = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_memRead = 1; ex_regW = 1; ex_rd = rd; id_rs1 = 5'd5; id_useRa = 1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b0;
        #12;
        chk("reset_outputs", vec, NONE);
        chk("reset_state", {8'd0, u_dut.state_q == MUL_WAIT}, 9'd0);
        @(negedge clk);
        rst = 1'b1;

        // Load-use on rs1, then rd=0, then rs2 path, then rs2 unused.
        cyc(); idle(); set_lu(5'd5); #1;
        chk("lu_rs1", vec, LU);
        cyc(); idle(); set_lu(5'd0); #1;
        chk("lu_rd0", vec, NONE);
        cyc(); idle(); ex_memRead = 1; ex_regW = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_useRb = 1; #1;
        chk("lu_rs2", vec, LU);
        cyc(); id_useRb = 0; #1;
        chk("lu_rs2_unused", vec, NONE);
        cyc(); idle(); set_lu(5'd5); ex_regW = 0; #1;
        chk("lu_no_regw", vec, NONE);

        // Redirect beats load-use and multiply.
        cyc(); idle(); set_lu(5'd5); ex_redirect = 1; #1;
        chk("redir_lu", vec, REDIR);
        cyc(); idle(); ex_redirect = 1; ex_mul = 1; #1;
        chk("redir_mul", vec, REDIR);
        cyc(); idle(); #1;
        chk("redir_no_wait", vec, NONE);

        // mem_busy beats redirect in RUN.
        cyc(); idle(); mem_busy = 1; ex_redirect = 1; set_lu(5'd5); #1;
        chk("membusy_run", vec, MEMB);

        // Multiply MUL_LAT=4, back-to-back; load-use/redirect ignored in wait.
        cyc(); idle(); ex_mul = 1; #1;
        chk("mul_c0", vec, MULS);
        cyc(); set_lu(5'd5); #1;
        chk("mul_c1_lu_ignored", vec, MULW);
        cyc(); idle(); ex_mul = 1; ex_redirect = 1; #1;
        chk("mul_c2_redir_ignored", vec, MULW);
        cyc(); ex_redirect = 0; #1;
        chk("mul_c3_done", vec, MULD);
        cyc(); #1;
        chk("mul2_c0", vec, MULS);
        cyc(); #1;
        chk("mul2_c1", vec, MULW);
        cyc(); #1;
        chk("mul2_c2", vec, MULW);
        cyc(); #1;
        chk("mul2_c3_done", vec, MULD);
        cyc(); idle(); #1;
        chk("mul2_after", vec, NONE);

        // mem_busy in MUL_WAIT with cnt=1.
        cyc(); ex_mul = 1; #1;
        chk("mb_c0", vec, MULS);
        cyc(); #1;
        chk("mb_c1", vec, MULW);
        for (int i = 0; i < 3; i++) begin
            cyc(); mem_busy = 1; #1;
            chk("mb_hold", vec, MEMBW);
            chk("mb_cnt", 9'(u_dut.cnt_q), 9'd1);
        end
        cyc(); mem_busy = 0; #1;
        chk("mb_after1", vec, MULW);
        cyc(); #1;
        chk("mb_after2_done", vec, MULD);
        cyc(); idle(); #1;
        chk("mb_end", vec, NONE);

        // Reset mid-multiply, then a fresh full multiply.
        cyc(); ex_mul = 1; #1;
        chk("rst_c0", vec, MULS);
        cyc(); #1;
        chk("rst_c1", vec, MULW);
        ex_mul = 0; rst = 1'b0; #1;
        chk("rst_async", vec, NONE);
        rst = 1'b1;
        cyc(); ex_mul = 1; #1;
        chk("rst_fresh_c0", vec, MULS);
        cyc(); #1;
        chk("rst_fresh_c1", vec, MULW);
        cyc(); #1;
        chk("rst_fresh_c2", vec, MULW);
        cyc(); #1;
        chk("rst_fresh_c3", vec, MULD);
        cyc(); idle(); #1;
        chk("rst_fresh_end", vec, NONE);

        // MUL_LAT=1: done in the detection cycle, never waits.
        cyc(); ex_mul1 = 1; #1;
        chk("lat1_c0", vec1, MUL1);
        cyc(); #1;
        chk("lat1_c1", vec1, MUL1);
        cyc(); ex_mul1 = 0; #1;
        chk("lat1_idle", vec1, NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
